// File: rtl/c3lib_cdc_hs_pkg.sv
// Shared types for both halves of the two-phase toggle CDC handshake.
package c3lib_cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

endpackage

// File: rtl/c3lib_cdc_hs_tx_if.sv
// Source-side word handshake. A word transfers at a rising clk edge where
// in_valid && in_ready; in_data is sampled only at that edge.
interface c3lib_cdc_hs_tx_if #(
  parameter int DWIDTH = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/c3lib_cdc_hs_tx_ack_sync.sv
// Two-flop, 1-bit synchronizer for the returning ack toggle.
module c3lib_cdc_hs_tx_ack_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* async_reg = "true" *) logic sync1;
  (* async_reg = "true" *) logic sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
    end
  end

  assign q = sync2;

endmodule

// File: rtl/c3lib_cdc_hs_tx.sv
// Transmit half of a two-phase toggle CDC handshake; holds xfer_data stable
// for the whole request/ack round trip. Optional ack timeout: C3LIB_CDC_HS_TX_TIMEOUT_EN.
module c3lib_cdc_hs_tx
  import c3lib_cdc_hs_pkg::*;
#(
  parameter int DWIDTH      = 8,
  parameter int RESET_VAL   = 0,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  c3lib_cdc_hs_tx_if.slave  in_if,
  output logic [DWIDTH-1:0] xfer_data,
  output logic              req_tgl,
  input  logic              ack_tgl_async,
  output logic              busy,
  output logic              timeout_err,
  output state_t            state
);

  localparam logic [DWIDTH-1:0] RST_PAT = (RESET_VAL == 0) ? '0 : '1;

  state_t state_q, state_d;
  logic   accept, flip, ack_s;

  c3lib_cdc_hs_tx_ack_sync u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_tgl_async),
    .q   (ack_s)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    flip    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_if.in_valid) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      // One full cycle of data setup before the request edge.
      SETUP: begin
        flip    = 1'b1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_s == req_tgl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_tgl   <= 1'b0;
      xfer_data <= RST_PAT;
    end else begin
      state_q <= state_d;
      if (flip)   req_tgl   <= ~req_tgl;
      if (accept) xfer_data <= in_if.in_data;
    end
  end

  assign in_if.in_ready = (state_q == IDLE) && !rst;
  assign busy           = (state_q != IDLE);
  assign state          = state_q;

`ifdef C3LIB_CDC_HS_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] to_cnt;

  // Count restarts on each entry to WAIT_ACK and stops at LIMIT; the error is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (state_q == SETUP) begin
      to_cnt <= '0;
    end else if ((state_q == WAIT_ACK) && (to_cnt != LIMIT)) begin
      to_cnt <= to_cnt + 1'b1;
      if (to_cnt == LIMIT - 1'b1) timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_c3lib_cdc_hs_tx.sv
// Directed bench for c3lib_cdc_hs_tx: reset, loopback, delayed ack, reset abort, timeout.
module tb_c3lib_cdc_hs_tx;
  import c3lib_cdc_hs_pkg::*;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          loop_mode;
  logic          ack_drv;
  logic          ack;
  logic [DW-1:0] xfer_data;
  logic          req_tgl;
  logic          busy;
  logic          timeout_err;
  state_t        state;

  logic [DW-1:0] exp_q[$];
  int            n_checks;
  int            n_errors;
  logic          exp_to;

  c3lib_cdc_hs_tx_if #(.DWIDTH(DW)) in_if ();

  c3lib_cdc_hs_tx #(
    .DWIDTH      (DW),
    .RESET_VAL   (0),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_if         (in_if.slave),
    .xfer_data     (xfer_data),
    .req_tgl       (req_tgl),
    .ack_tgl_async (ack),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .state         (state)
  );

  assign ack = loop_mode ? req_tgl : ack_drv;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: offer one word at the next edge and record it for the scoreboard
  task automatic offer(input logic [DW-1:0] w);
    in_if.in_valid = 1'b1;
    in_if.in_data  = w;
    exp_q.push_back(w);
  endtask

  task automatic check_word(input string tag);
    logic [DW-1:0] w;
    w = exp_q.pop_front();
    check(tag, xfer_data, w);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    loop_mode      = 1'b1;
    ack_drv        = 1'b0;
`ifdef C3LIB_CDC_HS_TX_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif

    // 1. reset held 3 cycles with in_valid high
    rst            = 1'b1;
    in_if.in_valid = 1'b1;
    in_if.in_data  = 8'h77;
    #1;
    check("rst_ready_pre", in_if.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready_hold", in_if.in_ready, 1'b0);
    end
    rst            = 1'b0;
    in_if.in_valid = 1'b0;
    #1;
    check("rst_req", req_tgl, 1'b0);
    check("rst_xfer", xfer_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", in_if.in_ready, 1'b1);
    check("rst_state", state, IDLE);
    check("rst_to", timeout_err, 1'b0);

    // 2. loopback single transfer
    offer(8'hA5);
    tick();                                   // E0
    in_if.in_valid = 1'b0;
    check_word("t2_xfer_e0");
    check("t2_req_e0", req_tgl, 1'b0);
    check("t2_busy_e0", busy, 1'b1);
    check("t2_state_e0", state, SETUP);
    tick();                                   // E1
    check("t2_req_e1", req_tgl, 1'b1);
    check("t2_state_e1", state, WAIT_ACK);
    tick(); tick();                           // E2, E3
    check("t2_ready_e3", in_if.in_ready, 1'b0);
    tick();                                   // E4
    check("t2_ready_e4", in_if.in_ready, 1'b1);
    check("t2_busy_e4", busy, 1'b0);

    // 3. back-to-back loopback, in_valid held: accepts at E0 and E5
    offer(8'hA5);
    tick();                                   // E0
    check_word("t3_xfer_e0");
    in_if.in_data = 8'h3C;
    exp_q.push_back(8'h3C);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("t3_xfer", xfer_data, (i < 5) ? 8'hA5 : 8'h3C);
      check("t3_req", req_tgl, (i < 6) ? 1'b0 : 1'b1);
      if (i == 4) check("t3_ready_e4", in_if.in_ready, 1'b1);
      if (i >= 5 && i <= 8) check("t3_ready_busy", in_if.in_ready, 1'b0);
      if (i == 5) begin
        check_word("t3_xfer_e5");
        in_if.in_valid = 1'b0;
      end
    end
    check("t3_ready_e9", in_if.in_ready, 1'b1);

    // 4. ack delayed 10 cycles, in_data toggling, in_valid held high
    loop_mode = 1'b0;
    ack_drv   = 1'b1;
    offer(8'hA5);
    tick();                                   // E0
    check_word("t4_xfer_e0");
    for (int i = 1; i <= 13; i++) begin
      in_if.in_data = (i % 2 == 1) ? 8'h5A : 8'hC3;
      tick();
      check("t4_ready", in_if.in_ready, 1'b0);
      check("t4_xfer", xfer_data, 8'hA5);
      check("t4_req", req_tgl, 1'b0);
      if (i == 11) ack_drv = 1'b0;
    end
    tick();                                   // E14: 3 edges after ack toggle
    check("t4_ready_done", in_if.in_ready, 1'b1);
    check("t4_xfer_done", xfer_data, 8'hA5);
    in_if.in_valid = 1'b0;

    // 5. reset pulse during WAIT_ACK
    loop_mode = 1'b1;
    offer(8'h3C);
    tick();                                   // E0
    in_if.in_valid = 1'b0;
    check_word("t5_xfer_e0");
    tick(); tick();                           // E1, E2
    check("t5_state_wait", state, WAIT_ACK);
    check("t5_req_wait", req_tgl, 1'b1);
    rst = 1'b1;
    tick();                                   // E3
    rst = 1'b0;
    #1;
    check("t5_state", state, IDLE);
    check("t5_req", req_tgl, 1'b0);
    check("t5_xfer", xfer_data, 8'h00);
    check("t5_ready", in_if.in_ready, 1'b1);
    offer(8'h96);
    tick();
    in_if.in_valid = 1'b0;
    check_word("t5_after_xfer");
    for (int i = 1; i <= 4; i++) tick();
    check("t5_after_ready", in_if.in_ready, 1'b1);
    check("t5_after_req", req_tgl, 1'b1);

    // 6. ack never returns: timeout after the 16th WAIT_ACK cycle
    loop_mode = 1'b0;
    ack_drv   = 1'b1;
    offer(8'h11);
    tick();                                   // E0
    in_if.in_valid = 1'b0;
    check_word("t6_xfer");
    tick();                                   // E1
    check("t6_req", req_tgl, 1'b0);
    for (int i = 2; i <= 16; i++) tick();     // E2..E16
    check("t6_to_e16", timeout_err, 1'b0);
    tick();                                   // E17
    check("t6_to_e17", timeout_err, exp_to);
    for (int i = 0; i < 5; i++) tick();
    check("t6_to_hold", timeout_err, exp_to);
    check("t6_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_to_rst", timeout_err, 1'b0);
    check("t6_state_rst", state, IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
